// File: rtl/dt_pkg.sv
// dt_pkg: image geometry, derived widths and FSM states shared by the
// sti unpacker and the distance-transform core.
package dt_pkg;
    localparam int IMG_W   = 128;
    localparam int IMG_H   = 128;
    localparam int WORD_W  = 16;
    localparam int STI_AW  = 10;
    localparam int RES_AW  = 14;
    localparam int ROW_W   = 7;
    localparam int COL_W   = 7;
    localparam int BIT_W   = $clog2(WORD_W);
    localparam int N_PIX   = IMG_W * IMG_H;
    localparam int N_WORDS = N_PIX / WORD_W;
    typedef enum logic [1:0] {IDLE, FETCH, STREAM, FIN} state_t;
endpackage

// File: rtl/dt_sti_unpack_if.sv
// dt_sti_unpack_if: sti ROM read port plus the tagged pixel stream.
interface dt_sti_unpack_if;
    import dt_pkg::*;
    logic              sti_rd;
    logic [STI_AW-1:0] sti_addr;
    logic [WORD_W-1:0] sti_di;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_data;
    logic [RES_AW-1:0] pix_addr;
    logic [ROW_W-1:0]  pix_row;
    logic [COL_W-1:0]  pix_col;
    logic              pix_border;
    logic              pix_last;
    modport master (
        output sti_rd, sti_addr, pix_valid, pix_data, pix_addr, pix_row, pix_col, pix_border, pix_last,
        input  sti_di, pix_ready
    );
    modport slave (
        input  sti_rd, sti_addr, pix_valid, pix_data, pix_addr, pix_row, pix_col, pix_border, pix_last,
        output sti_di, pix_ready
    );
endinterface

// File: rtl/dt_word_buf.sv
// dt_word_buf: current/next ROM word double buffer; serves the current word
// MSB first and swaps in the prefetched word without a bubble.
module dt_word_buf import dt_pkg::*; (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              fill,
    input  logic              adv,
    input  logic [WORD_W-1:0] din,
    output logic              bit_out,
    output logic              word_end
);
    logic [WORD_W-1:0] cur_word, nxt_word;
    logic [BIT_W-1:0]  bit_idx;
    logic              nxt_vld;

    assign bit_out  = cur_word[bit_idx];
    assign word_end = bit_idx == '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_word <= '0;
            nxt_word <= '0;
            bit_idx  <= '0;
            nxt_vld  <= 1'b0;
        end else begin
            if (fill) begin
                nxt_word <= din;
                nxt_vld  <= 1'b1;
            end
            if (load) begin
                cur_word <= din;
                bit_idx  <= BIT_W'(WORD_W - 1);
            end else if (adv) begin
                // bit_idx wraps from 0 back to the MSB of the next word
                bit_idx <= bit_idx - 1'b1;
                if (word_end && nxt_vld) cur_word <= nxt_word;
                if (word_end) nxt_vld <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/dt_sti_unpack.sv
// dt_sti_unpack: streams the packed sti ROM image as one tagged pixel per
// handshake in raster order, prefetching the next word during each word.
module dt_sti_unpack import dt_pkg::*; (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    dt_sti_unpack_if.master bus,
    output logic            busy,
    output logic            finish
);
    state_t            state, nxt_state;
    logic [RES_AW-1:0] addr;
    logic              hs, word_end, new_word, last_word;

    assign hs             = bus.pix_valid & bus.pix_ready;
    assign bus.pix_valid  = state == STREAM;
    assign bus.pix_addr   = addr;
    assign bus.pix_row    = addr[RES_AW-1 -: ROW_W];
    assign bus.pix_col    = addr[COL_W-1:0];
    assign bus.pix_border = bus.pix_row == '0 || bus.pix_row == ROW_W'(IMG_H - 1) ||
                            bus.pix_col == '0 || bus.pix_col == COL_W'(IMG_W - 1);
    assign bus.pix_last   = addr == RES_AW'(N_PIX - 1);
    assign busy           = state == FETCH || state == STREAM;
    assign finish         = state == FIN;
    // a word enters cur_word either from the initial fetch or on the bit-0 handshake
    assign new_word       = state == FETCH || (hs && word_end);
    assign last_word      = bus.sti_addr == STI_AW'(N_WORDS - 1);

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    nxt_state = start ? FETCH : IDLE;
            FETCH:   nxt_state = STREAM;
            STREAM:  nxt_state = hs && bus.pix_last ? FIN : STREAM;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bus.sti_rd   <= 1'b0;
            bus.sti_addr <= '0;
            addr         <= '0;
        end else begin
            state      <= nxt_state;
            bus.sti_rd <= (state == IDLE && start) || (new_word && !last_word);
            if (state == IDLE && start) bus.sti_addr <= '0;
            else if (new_word && !last_word) bus.sti_addr <= bus.sti_addr + 1'b1;
            if (hs) addr <= addr + 1'b1;
        end
    end

    dt_word_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (state == FETCH),
        .fill    (state == STREAM && bus.sti_rd),
        .adv     (hs),
        .din     (bus.sti_di),
        .bit_out (bus.pix_data),
        .word_end(word_end)
    );
endmodule

// File: tb/tb_dt_sti_unpack.sv
// tb_dt_sti_unpack: frames of directed/random ROM images with random
// back-pressure, checked pixel by pixel against a raster-order image model.
module tb_dt_sti_unpack;
    import dt_pkg::*;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic busy, finish;
    logic [WORD_W-1:0] rom [N_WORDS];
    int n_cmp = 0, n_bad = 0;

    dt_sti_unpack_if bus();
    dt_sti_unpack dut (.clk(clk), .reset(reset), .start(start), .bus(bus), .busy(busy), .finish(finish));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // expected stream entry for pixel i: {0, data, addr, row, col, border, last}
    function automatic logic [31:0] model(input int i);
        int r = i / IMG_W;
        int c = i % IMG_W;
        logic [WORD_W-1:0] w = rom[i / WORD_W];
        return {1'b0, w[WORD_W - 1 - i % WORD_W], 14'(i), 7'(r), 7'(c),
                r == 0 || r == IMG_H - 1 || c == 0 || c == IMG_W - 1, i == N_PIX - 1};
    endfunction

    function automatic logic [31:0] observed();
        return {1'b0, bus.pix_data, bus.pix_addr, bus.pix_row, bus.pix_col, bus.pix_border, bus.pix_last};
    endfunction

    task automatic run_frame(input string tag, input int rdy_pct, input int restart_at, input int abort_at);
        int cyc = 0, n = 0, unstable = 0, fin_cyc = 0, fin_cnt = 0, rd_cnt = 0, rd_bad = 0;
        int first_vld = 0, ones = 0, border = 0, exp_ones = 0, exp_border = 0, late_rd = 0;
        logic [31:0] obs, prev = '0, bad_obs = '0, bad_exp = '0, m;
        logic stalled = 1'b0, rdy, aborted = 1'b0, busy1 = 1'b0, found = 1'b0;
        for (int i = 0; i < N_PIX; i++) begin
            m = model(i);
            if (m[30]) exp_ones++;
            if (m[1]) exp_border++;
        end
        @(negedge clk);
        start = 1'b1;
        while (cyc < 40000 && !(fin_cnt > 0 && cyc > fin_cyc + 2)) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) busy1 = busy;
            if (bus.sti_rd) begin
                if (bus.sti_addr != 10'(rd_cnt)) rd_bad++;
                rd_cnt++;
                bus.sti_di = rom[bus.sti_addr];
            end
            if (finish) begin
                if (fin_cnt == 0) fin_cyc = cyc;
                fin_cnt++;
            end
            if (bus.pix_valid) begin
                obs = observed();
                if (first_vld == 0) first_vld = cyc;
                if (stalled && obs !== prev) unstable++;
                rdy = $urandom_range(99) < rdy_pct;
                if (rdy) begin
                    if (obs !== model(n) && !found) begin
                        found = 1'b1;
                        bad_obs = obs;
                        bad_exp = model(n);
                    end
                    if (bus.pix_data) ones++;
                    if (bus.pix_border) border++;
                    n++;
                end
                stalled = !rdy;
                prev = obs;
            end else begin
                rdy = 1'($urandom_range(1));
                stalled = 1'b0;
            end
            bus.pix_ready = rdy;
            if (n == restart_at && bus.pix_valid) start = 1'b1;
            if (n == abort_at) begin
                #2 reset = 1'b0;
                #1;
                chk({tag, " reset outputs"}, {bus.sti_rd, bus.sti_addr, bus.pix_valid, bus.pix_data,
                    bus.pix_addr, bus.pix_row, bus.pix_col, bus.pix_last, busy, finish}, '0);
                repeat (10) begin @(negedge clk); if (bus.sti_rd) late_rd++; end
                reset = 1'b1;
                repeat (10) begin @(negedge clk); if (bus.sti_rd) late_rd++; end
                chk({tag, " reads after reset"}, late_rd, 0);
                aborted = 1'b1;
                break;
            end
        end
        chk({tag, " first mismatching pixel"}, bad_obs, bad_exp);
        chk({tag, " first valid cycle"}, first_vld, 2);
        chk({tag, " busy after start"}, busy1, 1);
        if (!aborted) begin
            chk({tag, " pixel count"}, n, N_PIX);
            chk({tag, " finish pulses"}, fin_cnt, 1);
            chk({tag, " rom reads"}, rd_cnt, N_WORDS);
            chk({tag, " rom read order errors"}, rd_bad, 0);
            chk({tag, " stall instability"}, unstable, 0);
            chk({tag, " object pixels"}, ones, exp_ones);
            chk({tag, " border pixels"}, border, exp_border);
            chk({tag, " border count"}, border, 2 * IMG_W + 2 * IMG_H - 4);
            chk({tag, " busy after finish"}, busy, 0);
            if (rdy_pct == 100) chk({tag, " finish latency"}, fin_cyc, 16386);
        end
    endtask

    initial begin
        bus.pix_ready = 1'b0;
        bus.sti_di = '0;
        #1 reset = 1'b0;
        #1;
        chk("power-on reset", {bus.sti_rd, bus.sti_addr, bus.pix_valid, bus.pix_data, bus.pix_addr,
            bus.pix_row, bus.pix_col, bus.pix_last, busy, finish}, '0);
        @(negedge clk);
        reset = 1'b1;
        foreach (rom[i]) rom[i] = '0;
        rom[0] = 16'h8001;
        rom[N_WORDS - 1] = 16'h0001;
        run_frame("sparse", 100, -1, -1);
        foreach (rom[i]) rom[i] = 16'hAAAA;
        run_frame("checker", 80, 5000, -1);
        foreach (rom[i]) rom[i] = 16'($urandom);
        run_frame("abort", 50, -1, 8000);
        run_frame("after_abort", 85, -1, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dt_sti_unpack.md
Name: dt_sti_unpack

Overview:
Upstream feeder for the distance-transform core. Reads the packed binary image from the 1024x16 sti ROM and streams it as one pixel per handshake, in raster order, with row/col/linear-address tags and a border flag. The DT core consumes this stream for its forward pass instead of addressing sti ROM directly. The ROM is read bubble-free using a one-word prefetch.

Parameters:
IMG_W, 128, image width in pixels (multiple of WORD_W)
IMG_H, 128, image height in pixels
WORD_W, 16, bits per sti ROM word; pixel order within a word is MSB first

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
sti_rd  out  1  ROM read enable; ROM latches sti_M[sti_addr] on the following negedge
sti_addr  out  10  ROM word address
sti_di  in  16  ROM data; valid at the posedge that ends the sti_rd cycle
pix_valid  out  1  pixel stream valid
pix_ready  in  1  consumer accepts pixel; handshake = pix_valid & pix_ready at posedge
pix_data  out  1  pixel value (1 = object, 0 = background)
pix_addr  out  14  linear index, row*IMG_W+col (equals the res RAM address)
pix_row  out  7  row index
pix_col  out  7  column index
pix_border  out  1  row==0, row==IMG_H-1, col==0 or col==IMG_W-1
pix_last  out  1  high with pixel 16383
busy  out  1  high from the cycle after start is accepted until finish
finish  out  1  one-cycle pulse the cycle after the pix_last handshake

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; sti_rd=0, sti_addr=0, pix_valid=0, pix_data=0, pix_addr=0, row/col=0, pix_last=0, busy=0, finish=0; prefetch flag cleared. Reset mid-frame aborts immediately; no further ROM reads; a new start is required.
- States: IDLE -> FETCH -> STREAM -> FIN -> IDLE.
- IDLE: start=1 at a posedge -> FETCH; sti_rd=1, sti_addr=0, busy=1. start in any other state is ignored.
- FETCH (1 cycle): at the ending posedge, capture sti_di into cur_word, set bit_idx=15 and pix_valid=1 -> STREAM. First pixel is valid 2 posedges after the start sample.
- STREAM: pix_data=cur_word[bit_idx]. In the first cycle of each word k<1023, assert sti_rd for exactly one cycle with sti_addr=k+1; capture into nxt_word and set nxt_vld. The read is issued regardless of pix_ready.
- Handshake: on pix_valid&pix_ready, advance bit_idx, col, row and pix_addr. At bit_idx==0, load cur_word<-nxt_word, clear nxt_vld and set bit_idx=15 with no bubble. col wraps at IMG_W-1 to 0 and row increments.
- With pix_ready=0, all pix_* outputs hold stable and pix_valid stays high. Valid is never retracted.
- sti_addr holds its last value while sti_rd=0. sti_rd is never asserted for an address above 1023.
- pix_last=1 only when pix_addr==16383. Its handshake -> FIN: pix_valid=0, finish=1 for one cycle, busy=0 -> IDLE.
- Throughput: with pix_ready held high, a frame is 16384 consecutive handshakes; finish arrives 16386 cycles after start is sampled.
- pix_border is combinational from the row/col registers. No other output is combinational from inputs.
- Exactly 1024 ROM reads per frame, each address exactly once, ascending.

Decomposition:
- Shared package dt_pkg: IMG_W, IMG_H, WORD_W, derived widths (STI_AW=10, RES_AW=14, ROW_W=COL_W=7), and the state enum (IDLE, FETCH, STREAM, FIN). The DT core imports the same package.
- One natural sub-module, dt_word_buf: the cur_word/nxt_word double buffer with bit index and load/advance control.
- The FSM, coordinate counters and ROM interface stay in dt_sti_unpack.

Test Plan:
- All-zero ROM, pix_ready=1 -> 16384 pixels with pix_data=0, pix_addr 0..16383 ascending; pix_last only at 16383; finish exactly 16386 cycles after start.
- Word 0 = 16'h8001, rest 0 -> pix_data=1 only at addr 0 and 15. Word 1023 = 16'h0001 -> pix_data=1 only at addr 16383 (row 127, col 127, border=1).
- Checkerboard 16'hAAAA in all words -> pix_data = ~col[0]. pix_border=1 for exactly 508 pixels. Row increments at col 127->0.
- Random pix_ready (50%) -> stream identical to the ready=1 run. Outputs stable while stalled. Exactly 1024 sti_rd cycles with addresses 0..1023 each once.
- start re-pulsed at pixel 5000 -> ignored, frame unaffected. A second start after finish -> a full second frame is produced.
- reset asserted at pixel 8000 -> all outputs return to reset values asynchronously and no sti_rd follows. A subsequent start -> a full frame from addr 0.
